life_grid: RTL and testbench
============================

// Module: life_grid
// PURPOSE
//  Cell-storage and generation engine downstream of the game-control FSM.
//  - Holds the ROWSxCOLS board.
//  - Applies program-mode writes at the FSM's cell_idx.
//  - In RUN, computes each new Conway generation (B3/S23) one cell per clock into
//    a shadow buffer, then commits it atomically. board feeds the LED/display driver.
// PARAMETERS
//  ROWS   10  grid rows
//  COLS   10  grid columns; N = ROWS*COLS, N must be <= 2**IDX_W
//  IDX_W  7   width of cell_idx; index = row*COLS + col
//  GEN_W  16  width of gen_count
// PORTS
//  clka        in   1      system clock, all logic on rising edge
//  stop        in   1      synchronous reset, active-high
//  game_state  in   2      from FSM: 00 STOP, 01 PROGRAM, 10 RUN, 11 PAUSE
//  cell_idx    in   IDX_W  cell addressed by the FSM in PROGRAM
//  wr_en       in   1      write strobe for board[cell_idx]
//  wr_val      in   1      value written (1 = alive)
//  step_tick   in   1      request one generation (RUN only)
//  board       out  N      current generation, bit i = cell i
//  busy        out  1      generation in progress
//  gen_done    out  1      one-cycle pulse after each commit
//  gen_count   out  GEN_W  committed generations since reset
//  extinct     out  1      1 when board == 0
// BEHAVIOUR
//  Reset (stop=1 at an edge): highest priority, overrides all other inputs.
//  - board=0, shadow=0, scan=0, state=IDLE, busy=0, gen_done=0, gen_count=0.
//  - extinct is combinational from board, so it is 1 after reset.
//  States: IDLE -> CALC -> COMMIT -> IDLE. busy=1 in CALC and COMMIT.
//  IDLE:
//  - Write: game_state=01 & wr_en & cell_idx<N -> board[cell_idx]<=wr_val at that edge.
//    cell_idx>=N is ignored.
//  - game_state=10 & step_tick -> CALC with scan=0.
//  CALC: each edge sets shadow[scan] = rule(board[scan], live neighbours of scan);
//  scan++. Leaves for COMMIT after scan=N-1. Exactly N cycles.
//  - rule: alive & (2 or 3 neighbours) -> 1; dead & exactly 3 -> 1; else 0.
//  - Neighbours are always read from board (never shadow); count is 4-bit, 8 cells.
//  COMMIT (1 cycle): board<=shadow; gen_count++ (wraps max->0); gen_done=1 next cycle.
//  Latency: board changes N+1 edges after the edge that samples step_tick.
//  Boundary rules:
//  - step_tick while busy, or when game_state!=10: ignored, not queued.
//  - wr_en while busy, or when game_state!=01: ignored.
//  - game_state->01/11 during CALC: the generation still completes and commits.
//  - game_state->00 during CALC/COMMIT: abort; next edge -> IDLE, busy=0,
//    no commit, board and gen_count unchanged.
//  - step_tick on the same edge COMMIT finishes: ignored (state is not IDLE).
// CONFIGURATION
//  LIFE_TORUS_EN defined: edges wrap (row/col modulo ROWS/COLS); every cell has 8 neighbours.
//  LIFE_TORUS_EN undefined: off-grid neighbours count as dead (default).
// TESTING
//  1 Reset: stop=1 one edge -> board=0, gen_count=0, busy=0, extinct=1.
//  2 Write: gs=01, idx=45, wr_en=1, wr_val=1 -> board[45]=1 after edge.
//    idx=110 -> board unchanged. gs=10 with wr_en -> unchanged.
//  3 Blinker: set 44,45,46; gs=10; step_tick 1 cycle.
//    -> busy 101 cycles, gen_done pulse, board={35,45,55}, gen_count=1.
//    Second step -> {44,45,46}.
//  4 Still life: set {0,1,10,11}; step -> board unchanged, gen_count=1.
//    All-zero board, step -> still 0, extinct=1, gen_count increments.
//  5 Edge: set {0,10,20}; step.
//    Without LIFE_TORUS_EN -> {10,11}. With LIFE_TORUS_EN -> {10,11,19}.
//  6 Hazards: step_tick pulsed at scan=50 -> ignored, one commit only.
//    gs->00 at scan=50 -> busy=0 next edge, board and gen_count unchanged, no gen_done.

Source files
------------

// File: rtl/life_grid.sv
// life_grid: Conway B3/S23 board store with a one-cell-per-clock generation engine and atomic commit.
// Define LIFE_TORUS_EN to wrap neighbour lookups around the grid edges; otherwise off-grid cells count as dead.
module life_grid #(
    parameter int ROWS  = 10,
    parameter int COLS  = 10,
    parameter int IDX_W = 7,
    parameter int GEN_W = 16
) (
    input  logic                   clka,
    input  logic                   stop,
    input  logic [1:0]             game_state,
    input  logic [IDX_W-1:0]       cell_idx,
    input  logic                   wr_en,
    input  logic                   wr_val,
    input  logic                   step_tick,
    output logic [ROWS*COLS-1:0]   board,
    output logic                   busy,
    output logic                   gen_done,
    output logic [GEN_W-1:0]       gen_count,
    output logic                   extinct
);
    localparam int N = ROWS * COLS;
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);

    typedef enum logic [1:0] {
        GS_STOP    = 2'b00,
        GS_PROGRAM = 2'b01,
        GS_RUN     = 2'b10,
        GS_PAUSE   = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_COMMIT
    } state_e;

    state_e           state_q;
    logic [N-1:0]     board_q;
    logic [N-1:0]     shadow_q;
    logic [IDX_W-1:0] scan_q;
    logic [IDX_W-1:0] row_q;
    logic [IDX_W-1:0] col_q;
    logic             busy_q;
    logic             gen_done_q;
    logic [GEN_W-1:0] gen_count_q;

    logic [3:0]       nbr_cnt_d;
    logic             cell_d;

    // Row/column of the scanned cell are tracked as counters so no divider is needed.
    always_comb begin : nbr_count
        int               nr;
        int               nc;
        logic             valid;
        logic [IDX_W-1:0] nidx;
        nbr_cnt_d = '0;
        nr        = 0;
        nc        = 0;
        valid     = 1'b0;
        nidx      = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr    = int'(row_q) + dr;
                nc    = int'(col_q) + dc;
                valid = !(dr == 0 && dc == 0);
`ifdef LIFE_TORUS_EN
                if (nr < 0)          nr = ROWS - 1;
                else if (nr >= ROWS) nr = 0;
                if (nc < 0)          nc = COLS - 1;
                else if (nc >= COLS) nc = 0;
`else
                if (nr < 0 || nr >= ROWS || nc < 0 || nc >= COLS) valid = 1'b0;
`endif
                nidx = IDX_W'(nr * COLS + nc);
                if (valid && board_q[nidx]) nbr_cnt_d = nbr_cnt_d + 4'd1;
            end
        end
        cell_d = board_q[scan_q] ? (nbr_cnt_d == 4'd2 || nbr_cnt_d == 4'd3)
                                 : (nbr_cnt_d == 4'd3);
    end

    always_ff @(posedge clka) begin
        if (stop) begin
            // NOTE: the shadow buffer is cleared too, so a fresh board never inherits stale generation data.
            state_q     <= ST_IDLE;
            board_q     <= '0;
            shadow_q    <= '0;
            scan_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            busy_q      <= 1'b0;
            gen_done_q  <= 1'b0;
            gen_count_q <= '0;
        end else begin
            gen_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (game_state == GS_PROGRAM && wr_en && {1'b0, cell_idx} < N_EXT)
                        board_q[cell_idx] <= wr_val;
                    if (game_state == GS_RUN && step_tick) begin
                        state_q <= ST_CALC;
                        busy_q  <= 1'b1;
                        scan_q  <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                    end
                end
                ST_CALC: begin
                    if (game_state == GS_STOP) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        shadow_q[scan_q] <= cell_d;
                        if (scan_q == LAST_IDX) begin
                            state_q <= ST_COMMIT;
                        end else begin
                            scan_q <= scan_q + 1'b1;
                            if (col_q == LAST_COL) begin
                                col_q <= '0;
                                row_q <= row_q + 1'b1;
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (game_state != GS_STOP) begin
                        board_q     <= shadow_q;
                        gen_count_q <= gen_count_q + 1'b1;
                        gen_done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign board     = board_q;
    assign busy      = busy_q;
    assign gen_done  = gen_done_q;
    assign gen_count = gen_count_q;
    assign extinct   = ~|board_q;

endmodule

// File: tb/tb_life_grid.sv
// tb_life_grid: directed scenarios plus randomized traffic, every cycle compared against a
// generation-level model of the board (whole next generation computed at step acceptance).
module tb_life_grid;
    localparam int ROWS  = 10;
    localparam int COLS  = 10;
    localparam int IDX_W = 7;
    localparam int GEN_W = 16;
    localparam int N     = ROWS * COLS;

    logic             clka = 1'b0;
    logic             stop = 1'b1;
    logic [1:0]       game_state = 2'b00;
    logic [IDX_W-1:0] cell_idx = '0;
    logic             wr_en = 1'b0;
    logic             wr_val = 1'b0;
    logic             step_tick = 1'b0;
    logic [N-1:0]     board;
    logic             busy;
    logic             gen_done;
    logic [GEN_W-1:0] gen_count;
    logic             extinct;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    logic [N-1:0]     m_board = '0;
    logic [N-1:0]     m_next  = '0;
    logic [GEN_W-1:0] m_gen   = '0;
    logic             m_done  = 1'b0;
    logic             m_active = 1'b0;
    int               m_cnt   = 0;

    life_grid #(.ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W), .GEN_W(GEN_W)) dut (
        .clka      (clka),
        .stop      (stop),
        .game_state(game_state),
        .cell_idx  (cell_idx),
        .wr_en     (wr_en),
        .wr_val    (wr_val),
        .step_tick (step_tick),
        .board     (board),
        .busy      (busy),
        .gen_done  (gen_done),
        .gen_count (gen_count),
        .extinct   (extinct)
    );

    always #5 clka = ~clka;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] life(input logic [N-1:0] b);
        logic [N-1:0] nb;
        int cnt, rr, cc;
        nb = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
`ifdef LIFE_TORUS_EN
                        rr = (rr + ROWS) % ROWS;
                        cc = (cc + COLS) % COLS;
`else
                        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) continue;
`endif
                        cnt += int'(b[rr * COLS + cc]);
                    end
                end
                nb[r * COLS + c] = (cnt == 3) || (b[r * COLS + c] && cnt == 2);
            end
        end
        return nb;
    endfunction

    function automatic logic [N-1:0] cells(input int a, input int b, input int c, input int d);
        logic [N-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        if (d >= 0) v[d] = 1'b1;
        return v;
    endfunction

    always @(posedge clka) begin
        if (stop) begin
            m_board  <= '0;
            m_gen    <= '0;
            m_done   <= 1'b0;
            m_active <= 1'b0;
            m_cnt    <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                if (game_state == 2'b00) begin
                    m_active <= 1'b0;
                end else if (m_cnt == N) begin
                    m_board  <= m_next;
                    m_gen    <= m_gen + 1'b1;
                    m_done   <= 1'b1;
                    m_active <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else begin
                if (game_state == 2'b01 && wr_en && int'(cell_idx) < N)
                    m_board[cell_idx] <= wr_val;
                if (game_state == 2'b10 && step_tick) begin
                    m_active <= 1'b1;
                    m_cnt    <= 0;
                    m_next   <= life(m_board);
                end
            end
        end
    end

    always @(negedge clka) begin
        if (chk_en) begin
            check("board",     128'(board),     128'(m_board));
            check("busy",      128'(busy),      128'(m_active));
            check("gen_done",  128'(gen_done),  128'(m_done));
            check("gen_count", 128'(gen_count), 128'(m_gen));
            check("extinct",   128'(extinct),   128'(m_board == '0));
        end
    end

    task automatic do_reset();
        stop = 1'b1; game_state = 2'b00; wr_en = 1'b0; step_tick = 1'b0;
        @(negedge clka);
        stop = 1'b0;
    endtask

    task automatic write_cell(input int idx, input logic val);
        game_state = 2'b01; cell_idx = IDX_W'(idx); wr_val = val; wr_en = 1'b1;
        @(negedge clka);
        wr_en = 1'b0;
    endtask

    task automatic start_step();
        game_state = 2'b10; step_tick = 1'b1;
        @(negedge clka);
        step_tick = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 400) begin
            cyc++;
            @(negedge clka);
        end
        check("wait_idle", 128'(busy), 128'(0));
    endtask

    initial begin
        int cyc;
        int r;
        @(negedge clka);
        do_reset();
        chk_en = 1'b1;

        // Reset state
        check("rst_board",   128'(board),     128'(0));
        check("rst_gen",     128'(gen_count), 128'(0));
        check("rst_busy",    128'(busy),      128'(0));
        check("rst_extinct", 128'(extinct),   128'(1));

        // Writes: in range, out of range, wrong game state
        write_cell(45, 1'b1);
        check("wr45", 128'(board), 128'(cells(45, -1, -1, -1)));
        write_cell(110, 1'b1);
        check("wr110_ignored", 128'(board), 128'(cells(45, -1, -1, -1)));
        game_state = 2'b10; cell_idx = 7'd46; wr_val = 1'b1; wr_en = 1'b1;
        @(negedge clka);
        wr_en = 1'b0;
        check("wr_run_ignored", 128'(board), 128'(cells(45, -1, -1, -1)));

        // Blinker, two generations
        write_cell(44, 1'b1);
        write_cell(46, 1'b1);
        start_step();
        wait_idle(cyc);
        check("busy_cycles", 128'(cyc), 128'(N + 1));
        check("gen_done_pulse", 128'(gen_done), 128'(1));
        check("blinker1", 128'(board), 128'(cells(35, 45, 55, -1)));
        check("blinker1_gen", 128'(gen_count), 128'(1));
        start_step();
        wait_idle(cyc);
        check("blinker2", 128'(board), 128'(cells(44, 45, 46, -1)));
        check("blinker2_gen", 128'(gen_count), 128'(2));

        // Still life block, then empty board
        do_reset();
        write_cell(0, 1'b1); write_cell(1, 1'b1); write_cell(10, 1'b1); write_cell(11, 1'b1);
        start_step();
        wait_idle(cyc);
        check("block", 128'(board), 128'(cells(0, 1, 10, 11)));
        check("block_gen", 128'(gen_count), 128'(1));
        do_reset();
        start_step();
        wait_idle(cyc);
        check("empty_board", 128'(board), 128'(0));
        check("empty_extinct", 128'(extinct), 128'(1));
        check("empty_gen", 128'(gen_count), 128'(1));

        // Edge behaviour
        do_reset();
        write_cell(0, 1'b1); write_cell(10, 1'b1); write_cell(20, 1'b1);
        start_step();
        wait_idle(cyc);
`ifdef LIFE_TORUS_EN
        check("edge_torus", 128'(board), 128'(cells(10, 11, 19, -1)));
`else
        check("edge_flat", 128'(board), 128'(cells(10, 11, -1, -1)));
`endif

        // Hazard: step_tick mid-calculation is dropped
        do_reset();
        write_cell(44, 1'b1); write_cell(45, 1'b1); write_cell(46, 1'b1);
        start_step();
        repeat (49) @(negedge clka);
        step_tick = 1'b1;
        @(negedge clka);
        step_tick = 1'b0;
        wait_idle(cyc);
        repeat (150) @(negedge clka);
        check("midstep_gen", 128'(gen_count), 128'(1));
        check("midstep_board", 128'(board), 128'(cells(35, 45, 55, -1)));

        // Hazard: abort via STOP game state
        start_step();
        repeat (50) @(negedge clka);
        game_state = 2'b00;
        @(negedge clka);
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_board", 128'(board), 128'(cells(35, 45, 55, -1)));
        check("abort_gen", 128'(gen_count), 128'(1));
        check("abort_done", 128'(gen_done), 128'(0));

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 15000; i++) begin
            r = int'($urandom_range(0, 99));
            game_state = (r < 45) ? 2'b01 : (r < 93) ? 2'b10 : (r < 99) ? 2'b11 : 2'b00;
            cell_idx   = IDX_W'($urandom_range(0, 127));
            wr_en      = 1'($urandom_range(0, 1));
            wr_val     = ($urandom_range(0, 2) != 0);
            step_tick  = ($urandom_range(0, 19) == 0);
            stop       = ($urandom_range(0, 499) == 0);
            @(negedge clka);
        end
        stop = 1'b0; wr_en = 1'b0; step_tick = 1'b0;
        @(negedge clka);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
